// File: rtl/aliens_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aliens_bus_pkg
// Purpose  : Shared types and helpers for the bus cycle controller: FSM state
//            encoding, chip-select width, wait-state field width and the
//            chip-select decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package aliens_bus_pkg;

    localparam int NUM_CS = 8;
    localparam int WAIT_W = 3;
    localparam int IDX_W  = $clog2(NUM_CS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        ERROR   = 2'd2,
        RECOVER = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;  // exactly one select asserted
        logic [IDX_W-1:0] idx;    // index of the asserted select
    } cs_dec_t;

    // Decode active-low selects into a one-hot-valid flag and a binary index.
    // idx is only meaningful when valid is set.
    function automatic cs_dec_t cs_decode(input logic [NUM_CS-1:0] cs_n);
        cs_dec_t     r;
        int unsigned cnt;
        r   = '0;
        cnt = 0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (!cs_n[i]) begin
                cnt++;
                r.idx = IDX_W'(i);
            end
        end
        r.valid = (cnt == 1);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aliens_bus_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : aliens_bus_cycle_ctrl_if
// Purpose  : CPU-side request/response and device-side strobe bundle of the
//            bus cycle controller.
// Ports    : master - CPU/decoder side (drives req, rnw, cs_n)
//            slave  - controller side (drives cs_lat_n, rd_n, wr_n,
//                     cpu_ready, bus_err)
// Revision : 1.0 - initial release
// ============================================================================
interface aliens_bus_cycle_ctrl_if
    import aliens_bus_pkg::*;
#(
    parameter int NUM_CS = aliens_bus_pkg::NUM_CS
) ();

    logic              cpu_req;
    logic              cpu_rnw;
    logic [NUM_CS-1:0] cs_n;
    logic [NUM_CS-1:0] cs_lat_n;
    logic              rd_n;
    logic              wr_n;
    logic              cpu_ready;
    logic              bus_err;

    modport master (
        output cpu_req, cpu_rnw, cs_n,
        input  cs_lat_n, rd_n, wr_n, cpu_ready, bus_err
    );

    modport slave (
        input  cpu_req, cpu_rnw, cs_n,
        output cs_lat_n, rd_n, wr_n, cpu_ready, bus_err
    );

endinterface
`default_nettype wire

// File: rtl/aliens_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : aliens_watchdog
// Purpose  : Down-counting watchdog. Expiry issues an active-low reset pulse
//            of PULSE cycles, after which the counter reloads to TIMEOUT.
// Ports    : clk, rst_n    - clock, asynchronous active-low reset
//            en            - count enable (counter frozen while low)
//            kick          - reload request; ignored during a pulse
//            wdog_rst_n    - registered active-low reset request
// Revision : 1.0 - initial release
// ============================================================================
module aliens_watchdog
    import aliens_bus_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd60000,
    parameter logic [7:0]  PULSE   = 8'd16     // must be at least 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic en,
    input  wire logic kick,
    output logic      wdog_rst_n
);

    logic [15:0] cnt_q,  cnt_d;
    logic [7:0]  pcnt_q, pcnt_d;   // remaining low cycles after the current one
    logic        rstn_q, rstn_d;   // low while the pulse is active

    always_comb begin
        cnt_d  = cnt_q;
        pcnt_d = pcnt_q;
        rstn_d = rstn_q;
        if (!rstn_q) begin
            // Pulse in progress: runs to completion regardless of en or kick.
            if (pcnt_q == 8'd0) begin
                rstn_d = 1'b1;
                cnt_d  = TIMEOUT;
            end else begin
                pcnt_d = pcnt_q - 8'd1;
            end
        end else if (kick) begin
            // Checked before expiry so a kick on the expiry edge wins.
            cnt_d = TIMEOUT;
        end else if (en) begin
            if (cnt_q <= 16'd1) begin
                cnt_d  = 16'd0;
                rstn_d = 1'b0;
                pcnt_d = PULSE - 8'd1;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= TIMEOUT;
            pcnt_q <= 8'd0;
            rstn_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            pcnt_q <= pcnt_d;
            rstn_q <= rstn_d;
        end
    end

    assign wdog_rst_n = rstn_q;

endmodule
`default_nettype wire

// File: rtl/aliens_bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aliens_bus_cycle_ctrl
// Purpose  : Sequences CPU bus accesses after address decode: latches the
//            chip selects, drives read/write strobes for 1+W cycles, returns
//            a one-cycle ready (with bus_err on bad decodes) and hosts the
//            system watchdog kicked by writes to select WDOG_IDX.
// Ports    : clk, rst_n    - clock, asynchronous active-low reset
//            bus (slave)   - cpu_req/cpu_rnw/cs_n in; cs_lat_n/rd_n/wr_n/
//                            cpu_ready/bus_err out (all registered)
//            wdog_en       - watchdog count enable
//            wdog_rst_n    - watchdog reset request (active low)
// Revision : 1.0 - initial release
// ============================================================================
module aliens_bus_cycle_ctrl
    import aliens_bus_pkg::*;
#(
    parameter int                         NUM_CS       = aliens_bus_pkg::NUM_CS,
    parameter logic [NUM_CS*WAIT_W-1:0]   WAIT_CFG     = '0,
    parameter int                         WDOG_IDX     = 0,
    parameter logic [15:0]                WDOG_TIMEOUT = 16'd60000,
    parameter logic [7:0]                 WDOG_PULSE   = 8'd16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    aliens_bus_cycle_ctrl_if.slave  bus,
    input  wire logic               wdog_en,
    output logic                    wdog_rst_n
);

    localparam int PKG_CS = aliens_bus_pkg::NUM_CS;

    state_t              state_q, state_d;
    logic [NUM_CS-1:0]   cs_q, cs_d;          // selects latched in IDLE
    logic                rnw_q, rnw_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [NUM_CS-1:0]   cs_lat_n_q, cs_lat_n_d;
    logic                rd_n_q, rd_n_d;
    logic                wr_n_q, wr_n_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [PKG_CS-1:0]   w_cs_pad;
    cs_dec_t             w_dec;
    logic                w_kick;

    always_comb begin
        // Unused upper select lines read as deasserted.
        w_cs_pad                = '1;
        w_cs_pad[NUM_CS-1:0]    = bus.cs_n;
        w_dec                   = cs_decode(w_cs_pad);

        state_d    = state_q;
        cs_d       = cs_q;
        rnw_d      = rnw_q;
        wait_d     = wait_q;
        cs_lat_n_d = '1;
        rd_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        ready_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    cs_d  = bus.cs_n;
                    rnw_d = bus.cpu_rnw;
                    if (w_dec.valid) begin
                        state_d = ACCESS;
                        wait_d  = WAIT_CFG[int'(w_dec.idx)*WAIT_W +: WAIT_W];
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            ACCESS: begin
                // Strobes stay up through the ready cycle and drop after it.
                if (ready_q) begin
                    state_d = RECOVER;
                end else begin
                    cs_lat_n_d = cs_q;
                    rd_n_d     = !rnw_q;
                    wr_n_d     = rnw_q;
                    if (wait_q == '0) begin
                        ready_d = 1'b1;
                    end else begin
                        wait_d = wait_q - 1'b1;
                    end
                end
            end
            ERROR: begin
                ready_d = 1'b1;
                err_d   = 1'b1;
                state_d = RECOVER;
            end
            RECOVER: begin
                // Wait for the CPU to drop req so one request yields one ready.
                if (!bus.cpu_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Kick lands on the edge that raises ready for a watchdog write.
        w_kick = ready_d && (state_q == ACCESS) && !rnw_q && !cs_q[WDOG_IDX];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cs_q       <= '1;
            rnw_q      <= 1'b1;
            wait_q     <= '0;
            cs_lat_n_q <= '1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            rnw_q      <= rnw_d;
            wait_q     <= wait_d;
            cs_lat_n_q <= cs_lat_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    assign bus.cs_lat_n  = cs_lat_n_q;
    assign bus.rd_n      = rd_n_q;
    assign bus.wr_n      = wr_n_q;
    assign bus.cpu_ready = ready_q;
    assign bus.bus_err   = err_q;

    aliens_watchdog #(
        .TIMEOUT (WDOG_TIMEOUT),
        .PULSE   (WDOG_PULSE)
    ) u_wdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (wdog_en),
        .kick       (w_kick),
        .wdog_rst_n (wdog_rst_n)
    );

endmodule
`default_nettype wire

// File: tb/tb_aliens_bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aliens_bus_cycle_ctrl
// Purpose  : Scoreboard bench for aliens_bus_cycle_ctrl. Stimulus pushes the
//            expected completion of each access (and expected watchdog pulse
//            start cycles); monitors pop and compare when the DUT shows
//            cpu_ready or a falling wdog_rst_n. Cycle numbers are counted
//            from the negedge at which reset is released (cycle 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aliens_bus_cycle_ctrl;
    import aliens_bus_pkg::*;

    // sel0 W=1, sel2 W=3, sel5 W=0, sel7 W=7, all others 0
    localparam logic [23:0] WCFG = 24'hE000C1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wdog_en = 1'b0;
    logic wdog_rst_n;

    always #5 clk = ~clk;

    aliens_bus_cycle_ctrl_if #(.NUM_CS(8)) bus ();

    aliens_bus_cycle_ctrl #(
        .NUM_CS       (8),
        .WAIT_CFG     (WCFG),
        .WDOG_IDX     (0),
        .WDOG_TIMEOUT (16'd20),
        .WDOG_PULSE   (8'd4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .wdog_en    (wdog_en),
        .wdog_rst_n (wdog_rst_n)
    );

    typedef struct {
        logic       err;
        logic [7:0] cs;
        logic       rd;
        logic       wr;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   pq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   base = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // ---------------- completion scoreboard monitor ----------------
    always @(negedge clk) begin : mon_sb
        exp_t e;
        if (rst_n && bus.cpu_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ready: cpu_ready=1 at cycle %0d, required 0", cyc - base);
            end else begin
                e = sbq.pop_front();
                chk("ready_cycle", cyc - base, e.cyc);
                chk("ready_bus_err", bus.bus_err, e.err);
                chk("ready_cs_lat_n", bus.cs_lat_n, e.cs);
                chk("ready_rd_n", bus.rd_n, e.rd);
                chk("ready_wr_n", bus.wr_n, e.wr);
            end
        end
    end

    // ---------------- watchdog pulse monitor ----------------
    logic prev_w = 1'b1;
    int   low_len = 0;
    always @(negedge clk) begin : mon_wdog
        if (!rst_n) begin
            prev_w  = 1'b1;
            low_len = 0;
        end else begin
            if (!wdog_rst_n && prev_w) begin
                if (pq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_wdog_pulse: wdog_rst_n=0 at cycle %0d, required 1", cyc - base);
                end else begin
                    chk("wdog_pulse_start", cyc - base, pq.pop_front());
                end
                low_len = 1;
            end else if (!wdog_rst_n) begin
                low_len++;
            end else if (!prev_w) begin
                chk("wdog_pulse_width", low_len, 4);
            end
            prev_w = wdog_rst_n;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_rst(input string nm);
        chk({nm, "_cs_lat_n"}, bus.cs_lat_n, 8'hFF);
        chk({nm, "_rd_n"}, bus.rd_n, 1);
        chk({nm, "_wr_n"}, bus.wr_n, 1);
        chk({nm, "_cpu_ready"}, bus.cpu_ready, 0);
        chk({nm, "_bus_err"}, bus.bus_err, 0);
        chk({nm, "_wdog_rst_n"}, wdog_rst_n, 1);
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cs_n    = 8'hFF;
        bus.cpu_rnw = 1'b1;
        wdog_en     = en;
        repeat (2) @(negedge clk);
        check_rst("reset");
        rst_n = 1'b1;
        base  = cyc;
    endtask

    task automatic wait_until(input int rel);
        int guard;
        guard = 0;
        while ((cyc - base) < rel && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic wait_ready(input string nm, input bit idle_chk);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (idle_chk) begin
                chk({nm, "_idle_cs"}, bus.cs_lat_n, 8'hFF);
                chk({nm, "_idle_rd"}, bus.rd_n, 1);
                chk({nm, "_idle_wr"}, bus.wr_n, 1);
            end
            if (bus.cpu_ready === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: no cpu_ready within 30 cycles, required one", nm);
        end
    endtask

    // Push hand-computed completion {err, cs_lat_n, rd_n, wr_n, cycle}, run
    // one access, drop req at ready and idle two cycles (RECOVER -> IDLE).
    task automatic issue(input logic [7:0] cs, input logic rnw,
                         input logic e_err, input logic [7:0] e_cs,
                         input logic e_rd, input logic e_wr, input int lat,
                         input bit idle_chk, input string nm);
        exp_t e;
        e.err = e_err; e.cs = e_cs; e.rd = e_rd; e.wr = e_wr;
        e.cyc = (cyc - base) + lat;
        sbq.push_back(e);
        bus.cpu_req = 1'b1;
        bus.cs_n    = cs;
        bus.cpu_rnw = rnw;
        wait_ready(nm, idle_chk);
        bus.cpu_req = 1'b0;
        bus.cs_n    = 8'hFF;
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        exp_t e;
        bus.cpu_req = 1'b0;
        bus.cpu_rnw = 1'b1;
        bus.cs_n    = 8'hFF;

        // 1: basic read of select 2 (W=3): strobes cycles 2..5, ready at 5
        do_reset(1'b0);
        e = '{err: 1'b0, cs: 8'hFB, rd: 1'b0, wr: 1'b1, cyc: (cyc - base) + 5};
        sbq.push_back(e);
        bus.cpu_req = 1'b1; bus.cs_n = 8'hFB; bus.cpu_rnw = 1'b1;
        @(negedge clk);
        bus.cs_n = 8'h00; bus.cpu_rnw = 1'b0;   // latched values must win
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_cs_lat_n", bus.cs_lat_n, 8'hFB);
            chk("t1_rd_n", bus.rd_n, 0);
            chk("t1_wr_n", bus.wr_n, 1);
        end
        bus.cpu_req = 1'b0; bus.cs_n = 8'hFF; bus.cpu_rnw = 1'b1;
        @(negedge clk);
        chk("t1_rel_cs_lat_n", bus.cs_lat_n, 8'hFF);
        chk("t1_rel_rd_n", bus.rd_n, 1);
        @(negedge clk);

        // 2: zero-wait write of select 5, req held 10 cycles past ready
        e = '{err: 1'b0, cs: 8'hDF, rd: 1'b1, wr: 1'b0, cyc: (cyc - base) + 2};
        sbq.push_back(e);
        bus.cpu_req = 1'b1; bus.cs_n = 8'hDF; bus.cpu_rnw = 1'b0;
        wait_ready("t2_wr", 1'b0);
        repeat (10) @(negedge clk);
        chk("t2_hold_wr_n", bus.wr_n, 1);
        chk("t2_hold_cs_lat_n", bus.cs_lat_n, 8'hFF);
        bus.cpu_req = 1'b0; bus.cs_n = 8'hFF;
        repeat (2) @(negedge clk);
        issue(8'hDF, 1'b1, 1'b0, 8'hDF, 1'b0, 1'b1, 2, 1'b0, "t2_rd");

        // 3: decode errors, no select and two selects
        issue(8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 2, 1'b1, "t3_none");
        issue(8'hF3, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 2, 1'b1, "t3_multi");

        // req dropped mid-access: select 2 read still completes at +5
        e = '{err: 1'b0, cs: 8'hFB, rd: 1'b0, wr: 1'b1, cyc: (cyc - base) + 5};
        sbq.push_back(e);
        bus.cpu_req = 1'b1; bus.cs_n = 8'hFB; bus.cpu_rnw = 1'b1;
        repeat (2) @(negedge clk);
        bus.cpu_req = 1'b0; bus.cs_n = 8'hFF;
        wait_ready("t7_drop", 1'b0);
        repeat (2) @(negedge clk);

        // 6: reset during a W=7 write to select 7, then immediate new request
        bus.cpu_req = 1'b1; bus.cs_n = 8'h7F; bus.cpu_rnw = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_wr_active", bus.wr_n, 0);
        rst_n = 1'b0;
        #1;
        check_rst("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        bus.cs_n = 8'hFB; bus.cpu_rnw = 1'b1;
        e = '{err: 1'b0, cs: 8'hFB, rd: 1'b0, wr: 1'b1, cyc: 5};
        sbq.push_back(e);
        wait_ready("t6_after", 1'b0);
        bus.cpu_req = 1'b0; bus.cs_n = 8'hFF;
        repeat (2) @(negedge clk);

        // 4: free-running watchdog, pulses at 20 and 44; read of sel 0 no kick
        do_reset(1'b1);
        pq.push_back(20);
        pq.push_back(44);
        wait_until(5);
        issue(8'hFE, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b1, 3, 1'b0, "t4_rd");
        wait_until(50);
        chk("t4_pulses_seen", pq.size(), 0);
        wdog_en = 1'b0;

        // 5: write to sel 0 with ready on the expiry edge -> next pulse at 40
        do_reset(1'b1);
        pq.push_back(40);
        wait_until(17);
        issue(8'hFE, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 3, 1'b0, "t5_kick");
        wait_until(46);
        chk("t5_pulses_seen", pq.size(), 0);
        wdog_en = 1'b0;

        repeat (2) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
